// File: rtl/char_window_renderer.sv
// Single-glyph window renderer: scaled (1x/2x/4x) wrap-around window, per-line font
// row fetch during horizontal blanking, flashing, registered RGB output.
module char_window_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 400,
    parameter int V_TOTAL  = 449,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16,
    parameter int RGB_W    = 9,
    localparam int ROW_W   = $clog2(GLYPH_H),
    localparam int COL_W   = $clog2(GLYPH_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [9:0]         pixelCnt,
    input  logic [8:0]         lineCnt,
    input  logic [9:0]         posHorStart,
    input  logic [8:0]         posVerStart,
    input  logic [1:0]         scale,
    input  logic [RGB_W-1:0]   charRGB,
    input  logic [RGB_W-1:0]   bgRGB,
    input  logic               flashEn,
    input  logic               flashClk,
    output logic               readEn,
    output logic [ROW_W-1:0]   rowCnt,
    input  logic [GLYPH_W-1:0] fontBits,
    input  logic               fontValid,
    output logic               inWindow,
    output logic               fetchErr,
    output logic [RGB_W-1:0]   vgaRGB
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, READY} fetchState_t;

    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [8:0] VA     = 9'(V_ACTIVE);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    // Modulo subtraction without a divider: one conditional add of the active size.
    function automatic logic [9:0] wrapH(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[10]) d = d + 11'(H_ACTIVE);
        return d[9:0];
    endfunction

    function automatic logic [8:0] wrapV(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[9]) d = d + 10'(V_ACTIVE);
        return d[8:0];
    endfunction

    fetchState_t        state, stateNext;
    logic [9:0]         hStart;
    logic [8:0]         vStart;
    logic [1:0]         scaleSh;
    logic [1:0]         shiftAmt;
    logic [10:0]        winW;
    logic [9:0]         winH;
    logic [9:0]         dx;
    logic [8:0]         dy, dyNext, lineNext;
    logic               inH, inV, nextInV, glyphOn, frameEnd;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   rowNext;
    logic [GLYPH_W-1:0] rowBits;
    logic               rowValid, rowLoad, errSet;
    logic [RGB_W-1:0]   pixRGB_p0;

    // Stage p0: window geometry and pixel colour from the raw counters
    always_comb begin
        shiftAmt = (scaleSh == 2'd0) ? 2'd0 : ((scaleSh == 2'd1) ? 2'd1 : 2'd2);
        winW     = 11'(GLYPH_W) << shiftAmt;
        winH     = 10'(GLYPH_H) << shiftAmt;
        dx       = wrapH(pixelCnt, hStart);
        dy       = wrapV(lineCnt, vStart);
        lineNext = (lineCnt == V_LAST) ? 9'd0 : lineCnt + 9'd1;
        dyNext   = wrapV(lineNext, vStart);
        inH      = (pixelCnt < HA) && ({1'b0, dx} < winW);
        inV      = (lineCnt < VA) && ({1'b0, dy} < winH);
        nextInV  = (lineNext < VA) && ({1'b0, dyNext} < winH);
        col      = COL_W'(dx >> shiftAmt);
        rowNext  = ROW_W'(dyNext >> shiftAmt);
        frameEnd = (lineCnt == V_LAST) && (pixelCnt == H_LAST);
        glyphOn  = inH && inV && rowValid && rowBits[COL_W'(GLYPH_W - 1) - col]
                   && !(flashEn && flashClk);
        if (pixelCnt >= HA || lineCnt >= VA) pixRGB_p0 = '0;
        else if (glyphOn)                    pixRGB_p0 = charRGB;
        else                                 pixRGB_p0 = bgRGB;
    end

    // A late fontValid on the last blank pixel is still taken, but the FSM must be
    // back in IDLE before the next line's fetch point either way.
    always_comb begin
        stateNext = state;
        rowLoad   = 1'b0;
        errSet    = 1'b0;
        unique case (state)
            IDLE:  if (pixelCnt == HA && nextInV) stateNext = REQ;
            REQ:   stateNext = WAIT;
            WAIT: begin
                rowLoad = fontValid;
                if (pixelCnt == H_LAST) begin
                    stateNext = IDLE;
                    errSet    = !fontValid;
                end else if (fontValid) begin
                    stateNext = READY;
                end
            end
            READY: if (pixelCnt == H_LAST) stateNext = IDLE;
        endcase
    end

    assign readEn = (state == REQ);

    // Stage p1: registered control, fetched row and pixel output
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hStart   <= '0;
            vStart   <= '0;
            scaleSh  <= '0;
            rowCnt   <= '0;
            rowBits  <= '0;
            rowValid <= 1'b0;
            fetchErr <= 1'b0;
            inWindow <= 1'b0;
            vgaRGB   <= '0;
        end else begin
            state <= stateNext;
            if (frameEnd) begin
                hStart  <= posHorStart;
                vStart  <= posVerStart;
                scaleSh <= scale;
            end
            // The row belongs to exactly one line; it is invalid until refetched.
            if (pixelCnt == HA) rowValid <= 1'b0;
            if (state == IDLE && stateNext == REQ) rowCnt <= rowNext;
            if (rowLoad) begin
                rowBits  <= fontBits;
                rowValid <= 1'b1;
            end
            if (errSet) fetchErr <= 1'b1;
            inWindow <= inH && inV;
            vgaRGB   <= pixRGB_p0;
        end
    end

endmodule

// File: tb/tb_char_window_renderer.sv
// Scoreboard bench for char_window_renderer: scripted lines with random colours,
// flash phase, fetch latency and spurious fontValid, checked against a reference model.
module tb_char_window_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] pixelCnt;
    logic [8:0] lineCnt;
    logic [9:0] posHorStart;
    logic [8:0] posVerStart;
    logic [1:0] scale;
    logic [8:0] charRGB, bgRGB;
    logic       flashEn, flashClk;
    logic       readEn;
    logic [3:0] rowCnt;
    logic [7:0] fontBits;
    logic       fontValid;
    logic       inWindow, fetchErr;
    logic [8:0] vgaRGB;

    char_window_renderer dut (
        .clock(clock), .reset(reset), .pixelCnt(pixelCnt), .lineCnt(lineCnt),
        .posHorStart(posHorStart), .posVerStart(posVerStart), .scale(scale),
        .charRGB(charRGB), .bgRGB(bgRGB), .flashEn(flashEn), .flashClk(flashClk),
        .readEn(readEn), .rowCnt(rowCnt), .fontBits(fontBits), .fontValid(fontValid),
        .inWindow(inWindow), .fetchErr(fetchErr), .vgaRGB(vgaRGB)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] rgb;
        bit         inw;
        bit         rd;
        bit         err;
        bit         chkRow;
        logic [3:0] row;
        int         p;
        int         l;
    } exp_t;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nFail   = 0;

    // Reference model state: shadowed geometry and the row fetched for the next line
    int         mH, mV, mS;
    bit         mRowValid, mArmed, mErr;
    logic [7:0] mRowBits, mPendBits;
    logic [7:0] fontMem [16];

    bit         respPending;
    int         respCnt;
    logic [3:0] respRow;

    function automatic int shiftOf(input int sc);
        return (sc == 0) ? 0 : ((sc == 1) ? 1 : 2);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want,
                         input int p, input int l);
        nChecks++;
        if (got !== want) begin
            nFail++;
            if (nFail <= 20)
                $display("FAIL %s line %0d pix %0d: got %0h expected %0h", nm, l, p, got, want);
        end
    endtask

    task automatic driveCycle(input int p, input int l, input bit withhold, input bit rst);
        exp_t e;
        int   s, dx, dy, nl, dyn;
        bit   inw;
        @(negedge clock);
        fontValid = 1'b0;
        fontBits  = 8'($urandom);
        if (readEn) begin
            respRow     = rowCnt;
            respCnt     = $urandom_range(1, 100);
            respPending = !withhold;
        end else if (respPending) begin
            respCnt--;
            if (respCnt == 0) begin
                fontValid   = 1'b1;
                fontBits    = fontMem[respRow];
                respPending = 1'b0;
            end
        end else if ((p < 600 || (p >= 780 && p < 799 && !withhold)) && $urandom_range(0, 15) == 0) begin
            fontValid = 1'b1;
        end
        if (rst) respPending = 1'b0;

        pixelCnt = 10'(p);
        lineCnt  = 9'(l);
        reset    = rst;
        charRGB  = 9'($urandom);
        bgRGB    = 9'($urandom);
        flashClk = 1'($urandom);

        e.p = p; e.l = l; e.rd = 1'b0; e.chkRow = 1'b0; e.row = '0;
        if (rst) begin
            e.rgb = '0; e.inw = 1'b0; e.err = 1'b0; e.chkRow = 1'b1;
            mH = 0; mV = 0; mS = 0;
            mRowValid = 1'b0; mRowBits = '0; mArmed = 1'b0; mErr = 1'b0;
        end else begin
            s   = shiftOf(mS);
            dx  = (p - mH + 640) % 640;
            dy  = (l - mV + 400) % 400;
            inw = (p < 640) && (l < 400) && (dx < (8 << s)) && (dy < (16 << s));
            e.inw = inw;
            if (p >= 640 || l >= 400)
                e.rgb = '0;
            else if (inw && mRowValid && mRowBits[7 - (dx >> s)] && !(flashEn && flashClk))
                e.rgb = charRGB;
            else
                e.rgb = bgRGB;
            if (p == 640) begin
                nl        = (l == 448) ? 0 : l + 1;
                dyn       = (nl - mV + 400) % 400;
                mRowValid = 1'b0;
                mArmed    = (nl < 400) && (dyn < (16 << s));
                if (mArmed) begin
                    e.rd      = 1'b1;
                    e.chkRow  = 1'b1;
                    e.row     = 4'(dyn >> s);
                    mPendBits = fontMem[dyn >> s];
                end
            end
            if (p == 799) begin
                if (mArmed) begin
                    if (withhold) mErr = 1'b1;
                    else begin
                        mRowValid = 1'b1;
                        mRowBits  = mPendBits;
                    end
                end
                mArmed = 1'b0;
                if (l == 448) begin
                    mH = int'(posHorStart);
                    mV = int'(posVerStart);
                    mS = int'(scale);
                end
            end
            e.err = mErr;
        end
        sbq.push_back(e);
    endtask

    task automatic playLine(input int l, input bit withhold, input int resetAt);
        for (int p = 0; p < 800; p++) driveCycle(p, l, withhold, p == resetAt);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("vgaRGB", 32'(vgaRGB), 32'(e.rgb), e.p, e.l);
                check("inWindow", 32'(inWindow), 32'(e.inw), e.p, e.l);
                check("readEn", 32'(readEn), 32'(e.rd), e.p, e.l);
                check("fetchErr", 32'(fetchErr), 32'(e.err), e.p, e.l);
                if (e.chkRow) check("rowCnt", 32'(rowCnt), 32'(e.row), e.p, e.l);
            end
        end
    end

    initial begin
        reset = 1'b1; pixelCnt = '0; lineCnt = '0; posHorStart = '0; posVerStart = '0;
        scale = '0; charRGB = '0; bgRGB = '0; flashEn = 1'b0; flashClk = 1'b0;
        fontBits = '0; fontValid = 1'b0;
        respPending = 1'b0; respCnt = 0; respRow = '0;
        mH = 0; mV = 0; mS = 0; mRowValid = 1'b0; mArmed = 1'b0; mErr = 1'b0;
        mRowBits = '0; mPendBits = '0;
        for (int r = 0; r < 16; r++) fontMem[r] = 8'hA5;

        driveCycle(0, 0, 1'b0, 1'b1);
        driveCycle(1, 0, 1'b0, 1'b1);

        // 1x window at (100,50), every row A5
        posHorStart = 10'd100; posVerStart = 9'd50; scale = 2'd0;
        playLine(448, 1'b0, -1);
        for (int l = 48; l <= 66; l++) playLine(l, 1'b0, -1);

        // 2x window wrapping both edges from (636,396)
        for (int r = 0; r < 16; r++) fontMem[r] = 8'($urandom);
        fontMem[0] = 8'hFF;
        posHorStart = 10'd636; posVerStart = 9'd396; scale = 2'd1;
        playLine(448, 1'b0, -1);
        playLine(448, 1'b0, -1);
        playLine(0, 1'b0, -1);
        playLine(1, 1'b0, -1);
        for (int l = 395; l <= 398; l++) playLine(l, 1'b0, -1);
        playLine(427, 1'b0, -1);
        playLine(428, 1'b0, -1);
        playLine(429, 1'b0, -1);

        // Missed fetch deadline
        for (int r = 0; r < 16; r++) fontMem[r] = 8'($urandom);
        posHorStart = 10'd100; posVerStart = 9'd50; scale = 2'd0;
        playLine(448, 1'b0, -1);
        playLine(448, 1'b0, -1);
        playLine(59, 1'b0, -1);
        playLine(60, 1'b1, -1);
        playLine(61, 1'b0, -1);
        playLine(62, 1'b0, -1);

        // Flashing
        flashEn = 1'b1;
        for (int l = 50; l <= 55; l++) playLine(l, 1'b0, -1);
        flashEn = 1'b0;
        playLine(56, 1'b0, -1);
        playLine(57, 1'b0, -1);

        // Mid-frame position change only lands at the frame boundary
        playLine(199, 1'b0, -1);
        posHorStart = 10'd300;
        playLine(200, 1'b0, -1);
        playLine(55, 1'b0, -1);
        playLine(56, 1'b0, -1);
        playLine(448, 1'b0, -1);
        playLine(55, 1'b0, -1);
        playLine(56, 1'b0, -1);

        // Reset while waiting for font data, then fetch resumes with reset geometry
        playLine(56, 1'b1, 700);
        for (int l = 5; l <= 7; l++) playLine(l, 1'b0, -1);

        // Reserved scale code acts as 4x
        for (int r = 0; r < 16; r++) fontMem[r] = 8'($urandom);
        posHorStart = 10'd10; posVerStart = 9'd10; scale = 2'd3;
        playLine(448, 1'b0, -1);
        playLine(448, 1'b0, -1);
        for (int l = 9; l <= 12; l++) playLine(l, 1'b0, -1);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
        #2;
        if (sbq.size() > 0) begin
            nChecks++;
            nFail++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/char_window_renderer.md
Name: char_window_renderer

Overview:
- Parametrised successor of the single-glyph character handler in the VGA controller path.
- Renders one glyph inside a positioned window, with integer scaling (1x/2x/4x) and wrap-around in both axes.
- Fetches each glyph row from font memory through a req/valid handshake during horizontal blanking.
- Supports flashing, and drives registered 9-bit RGB to the VGA output stage.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 400, active lines per frame
- V_TOTAL, 449, lines per frame including blanking
- GLYPH_W, 8, glyph width in pixels (font row width in bits)
- GLYPH_H, 16, glyph height in rows
- RGB_W, 9, colour bus width

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pixelCnt  in  10  horizontal counter, 0..H_TOTAL-1
- lineCnt  in  9  vertical counter, 0..V_TOTAL-1
- posHorStart  in  10  window left edge, 0..H_ACTIVE-1
- posVerStart  in  9  window top edge, 0..V_ACTIVE-1
- scale  in  2  0=1x, 1=2x, 2=4x, 3=4x (reserved)
- charRGB  in  RGB_W  glyph foreground colour
- bgRGB  in  RGB_W  active-region background colour
- flashEn  in  1  enable flashing
- flashClk  in  1  flash phase; glyph hidden while 1 and flashEn=1
- readEn  out  1  font row request, one-cycle pulse
- rowCnt  out  clog2(GLYPH_H)  glyph row address, valid while readEn=1
- fontBits  in  GLYPH_W  font row data, MSB = leftmost pixel
- fontValid  in  1  fontBits valid this cycle
- inWindow  out  1  registered: current output pixel lies in the window
- fetchErr  out  1  sticky: a row fetch missed its deadline
- vgaRGB  out  RGB_W  registered pixel colour

Behaviour:
- Reset values: vgaRGB=0, readEn=0, rowCnt=0, inWindow=0, fetchErr=0; FSM=IDLE; row register=0 (invalid); shadow registers: position 0, scale 0.
- Shadowing: posHorStart, posVerStart and scale are captured only at the frame boundary (lineCnt=V_TOTAL-1 and pixelCnt=H_TOTAL-1). Mid-frame changes take effect next frame; no tearing.
- Window size: Wd = GLYPH_W<<s and Ht = GLYPH_H<<s, with s = 0/1/2 (scale 3 gives s=2).
- Horizontal membership: dx = (pixelCnt - hStart) mod H_ACTIVE; pixel is in window if pixelCnt<H_ACTIVE and dx<Wd. Vertical uses dy = (lineCnt - vStart) mod V_ACTIVE with Ht, and is computed the same way.
- Wrap-around: a window crossing the right/bottom edge continues at column/line 0 in the same frame.
- Glyph coordinates: column = dx>>s, row = dy>>s.
- Fetch FSM: IDLE, REQ, WAIT, READY.
  - At pixelCnt=H_ACTIVE (start of h-blank), compute the next line (lineCnt+1, or 0 after V_TOTAL-1). If that line is in the window vertically: go to REQ, clear the row valid flag.
  - REQ (1 cycle): readEn=1, rowCnt = glyph row of next line; then go to WAIT.
  - WAIT: on fontValid, latch fontBits and go to READY.
  - If pixelCnt reaches H_TOTAL-1 while still in WAIT: set fetchErr, go to IDLE, row stays invalid, so the line renders background.
  - READY: at pixelCnt=H_TOTAL-1, go to IDLE, keeping the row for the displayed line.
  - fontValid outside WAIT is ignored.
- Pixel output, 1-cycle latency from pixelCnt/lineCnt:
  - If pixelCnt>=H_ACTIVE or lineCnt>=V_ACTIVE: vgaRGB=0.
  - Else if in window, row valid, bit fontBits[GLYPH_W-1-column]=1, and not (flashEn & flashClk): vgaRGB=charRGB.
  - Else: vgaRGB=bgRGB.
  - inWindow has the same latency.
- Arithmetic: modulo subtraction is done as a difference plus conditional add of H_ACTIVE/V_ACTIVE, with no divider. All counters and offsets are unsigned.
- Reset during WAIT returns to IDLE, discards the row and clears fetchErr.

Test Plan:
- scale=0, pos=(100,50), font row = 8'hA5 for all rows, flashEn=0 -> line 50: vgaRGB=charRGB at outputs for pixelCnt 100,102,105,107; bgRGB elsewhere in 100..107; 0 at pixelCnt>=640. readEn pulses once per line for lines 49..64 (fetching next line), with rowCnt 0..15.
- scale=1, pos=(636,396), row 0 = 8'hFF -> window is 16x32. Line 396: charRGB at pixels 636..639 and 0..11. Line 0 shows row 2 (dy=4>>1). No window on line 428.
- fontValid withheld for a whole h-blank -> fetchErr=1 sticky; next line in window is all bgRGB; readEn timing unchanged on later lines.
- flashEn=1, flashClk toggled -> glyph pixels show bgRGB while flashClk=1 and charRGB while 0; flashEn=0 ignores flashClk.
- posHorStart changed from 100 to 300 mid-frame at line 200 -> the rest of that frame renders at 100; the next frame renders at 300.
- reset asserted for 1 cycle in WAIT -> next cycle vgaRGB=0, readEn=0, fetchErr=0, FSM=IDLE; normal fetch resumes on the next qualifying h-blank.
